// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dm_pkg
//  Purpose  : Shared encodings and address helper for the byte-lane data
//             memory (access sizes, fault causes, byte offset computation).
//  Revision : 1.0  initial release
// ============================================================================
package dm_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'b00,
      CAUSE_MISALIGN = 2'b01,
      CAUSE_RANGE    = 2'b10,
      CAUSE_SIZE     = 2'b11
   } cause_e;

   // Byte offset from the memory base, wrapping mod 2^32 so that addresses
   // below the base become huge offsets and fall out of range.
   function automatic logic [31:0] addr_to_offset(input logic [31:0] addr,
                                                  input logic [31:0] base);
      return addr - base;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dm_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : dm_load_align
//  Purpose  : Picks the addressed byte/half out of a little-endian word and
//             sign- or zero-extends it to 32 bits.
//  Revision : 1.0  initial release
// ============================================================================
module dm_load_align
   import dm_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  lane_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   output logic [31:0] data_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   size_e       w_size;

   assign w_size = size_e'(size_i);

   // Lane select followed by extension; word and reserved sizes pass through.
   always_comb begin
      w_byte = word_i[8*lane_i +: 8];
      w_half = lane_i[1] ? word_i[31:16] : word_i[15:0];
      data_o = word_i;
      case (w_size)
         SZ_BYTE: data_o = {{24{~unsigned_i & w_byte[7]}}, w_byte};
         SZ_HALF: data_o = {{16{~unsigned_i & w_half[15]}}, w_half};
         default: data_o = word_i;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/data_memory_bytelane.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_bytelane
//  Purpose  : Byte/half/word data memory with sign/zero-extending loads,
//             combinational or registered read, fault detection with a
//             sticky first-fault record, and saturating access counters.
//  Revision : 1.0  initial release
// ============================================================================
module data_memory_bytelane
   import dm_pkg::*;
#(
   parameter int          MEMORY_DEPTH = 1024,
   parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
   parameter int          SYNC_READ    = 0,
   parameter int          COUNT_WIDTH  = 16
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            address_i,
   input  logic [31:0]            write_data_i,
   input  logic                   mem_write_i,
   input  logic                   mem_read_i,
   input  logic [1:0]             size_i,
   input  logic                   unsigned_i,
   output logic [31:0]            data_o,
   output logic                   rvalid_o,
   output logic                   fault_o,
   output logic [1:0]             fault_cause_o,
   output logic [31:0]            fault_addr_o,
   input  logic                   fault_clear_i,
   output logic [COUNT_WIDTH-1:0] load_count_o,
   output logic [COUNT_WIDTH-1:0] store_count_o
);

   localparam int IDX_W = $clog2(MEMORY_DEPTH);

   logic [31:0]            mem_q [MEMORY_DEPTH];

   logic [31:0]            w_offset;
   logic [IDX_W-1:0]       w_index;
   logic [1:0]             w_lane;
   logic                   w_range_err;
   size_e                  w_size;
   cause_e                 w_cause;
   logic                   w_fault_now;
   logic                   w_load_ok;
   logic                   w_store_ok;
   logic [3:0]             w_be;
   logic [31:0]            w_wdata;
   logic [31:0]            w_load_data;

   logic                   fault_q,  fault_d;
   logic [1:0]             cause_q,  cause_d;
   logic [31:0]            faddr_q,  faddr_d;
   logic [COUNT_WIDTH-1:0] lcnt_q,   lcnt_d;
   logic [COUNT_WIDTH-1:0] scnt_q,   scnt_d;

   assign w_offset    = addr_to_offset(address_i, BASE_ADDR);
   assign w_index     = w_offset[IDX_W+1:2];
   assign w_lane      = w_offset[1:0];
   assign w_range_err = |w_offset[31:IDX_W+2];
   assign w_size      = size_e'(size_i);

   // Fault classification in priority order: size, range, alignment.
   always_comb begin
      w_cause = CAUSE_NONE;
      if (w_size == SZ_RSVD)
         w_cause = CAUSE_SIZE;
      else if (w_range_err)
         w_cause = CAUSE_RANGE;
      else if ((w_size == SZ_HALF && w_lane[0]) ||
               (w_size == SZ_WORD && w_lane != 2'b00))
         w_cause = CAUSE_MISALIGN;
   end

   assign w_fault_now = (mem_read_i | mem_write_i) & (w_cause != CAUSE_NONE);
   assign w_load_ok   = mem_read_i  & ~w_fault_now;
   // A write landing on an edge while reset is held must not happen.
   assign w_store_ok  = mem_write_i & ~w_fault_now & reset;

   // Store lane enables and replicated store data, mirroring the load mapping.
   always_comb begin
      w_be    = 4'b0000;
      w_wdata = write_data_i;
      case (w_size)
         SZ_BYTE: begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{write_data_i[7:0]}};
         end
         SZ_HALF: begin
            w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{write_data_i[15:0]}};
         end
         SZ_WORD: w_be = 4'b1111;
         default: w_be = 4'b0000;
      endcase
   end

   // RAM array: per-lane write, contents deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_store_ok) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) mem_q[w_index][8*i +: 8] <= w_wdata[8*i +: 8];
         end
      end
   end

   dm_load_align u_load_align (
      .word_i     (mem_q[w_index]),
      .lane_i     (w_lane),
      .size_i     (size_i),
      .unsigned_i (unsigned_i),
      .data_o     (w_load_data)
   );

   generate
      if (SYNC_READ != 0) begin : g_sync_read
         logic [31:0] rdata_q;
         logic        rvalid_q;

         // Registered read port: captures pre-write data, one-cycle valid pulse.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               rdata_q  <= 32'd0;
               rvalid_q <= 1'b0;
            end else begin
               rvalid_q <= w_load_ok;
               if (mem_read_i) rdata_q <= w_load_ok ? w_load_data : 32'd0;
            end
         end

         assign data_o   = rdata_q;
         assign rvalid_o = rvalid_q;
      end else begin : g_comb_read
         assign rvalid_o = w_load_ok & reset;
         assign data_o   = (w_load_ok & reset) ? w_load_data : 32'd0;
      end
   endgenerate

   // Sticky fault next state: a new fault wins over a simultaneous clear.
   always_comb begin
      fault_d = fault_q;
      cause_d = cause_q;
      faddr_d = faddr_q;
      if (w_fault_now && (!fault_q || fault_clear_i)) begin
         fault_d = 1'b1;
         cause_d = w_cause;
         faddr_d = address_i;
      end else if (fault_clear_i) begin
         fault_d = 1'b0;
         cause_d = CAUSE_NONE;
         faddr_d = 32'd0;
      end
   end

   // Saturating access counters.
   always_comb begin
      lcnt_d = lcnt_q;
      scnt_d = scnt_q;
      if (w_load_ok && !(&lcnt_q))                 lcnt_d = lcnt_q + COUNT_WIDTH'(1);
      if (mem_write_i && !w_fault_now && !(&scnt_q)) scnt_d = scnt_q + COUNT_WIDTH'(1);
   end

   // Fault record and counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fault_q <= 1'b0;
         cause_q <= 2'b00;
         faddr_q <= 32'd0;
         lcnt_q  <= '0;
         scnt_q  <= '0;
      end else begin
         fault_q <= fault_d;
         cause_q <= cause_d;
         faddr_q <= faddr_d;
         lcnt_q  <= lcnt_d;
         scnt_q  <= scnt_d;
      end
   end

   assign fault_o       = fault_q;
   assign fault_cause_o = cause_q;
   assign fault_addr_o  = faddr_q;
   assign load_count_o  = lcnt_q;
   assign store_count_o = scnt_q;

endmodule
`default_nettype wire
